// File: rtl/lsf_hit_sequencer_if.sv
// Engine-facing stream of the Legendre segment finder front end:
// one RoI strobe, a ready/valid hit stream tagged with its source
// channel, and the end-of-window pulse.
interface lsf_hit_sequencer_if #(
   parameter int N_CH  = 3,
   parameter int HIT_W = 16,
   parameter int ROI_W = 24,
   parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
   logic [ROI_W-1:0] out_roi;
   logic             out_roi_vld;
   logic [HIT_W-1:0] out_hit;
   logic [CH_W-1:0]  out_hit_ch;
   logic             out_hit_vld;
   logic             out_hit_rdy;
   logic             o_eof;

   // Sequencer side
   modport master (
      output out_roi, out_roi_vld, out_hit, out_hit_ch, out_hit_vld, o_eof,
      input  out_hit_rdy
   );

   // Engine side
   modport slave (
      input  out_roi, out_roi_vld, out_hit, out_hit_ch, out_hit_vld, o_eof,
      output out_hit_rdy
   );
endinterface

// File: rtl/lsf_hit_sequencer.sv
// Legendre segment finder hit sequencer: buffers N_CH hit streams and one
// RoI stream in FIFOs, then per RoI emits the RoI, round-robin hits for a
// programmable window, and an end-of-window pulse. Includes a spy ring of
// accepted hits that can be frozen for readout.
module lsf_hit_sequencer #(
   parameter int N_CH       = 3,
   parameter int HIT_W      = 16,
   parameter int ROI_W      = 24,
   parameter int FIFO_AW    = 5,
   parameter int ROI_AW     = 2,
   parameter int AF_MARGIN  = 4,
   parameter int DROP_STALE = 0,
   parameter int SPY_AW     = 6,
   parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                   clock,
   input  logic                   resetbar,
   input  logic [N_CH*HIT_W-1:0]  mdt_hit,
   input  logic [N_CH-1:0]        mdt_hit_we,
   output logic [N_CH-1:0]        mdt_hit_af,
   output logic [N_CH-1:0]        hit_ovf,
   input  logic [ROI_W-1:0]       roi,
   input  logic                   roi_we,
   output logic                   roi_af,
   input  logic [9:0]             histogram_accumulation_count,
   input  logic                   i_eof,
   lsf_hit_sequencer_if.master    eng,
   input  logic                   freeze,
   input  logic [SPY_AW-1:0]      spy_addr,
   output logic [HIT_W+CH_W-1:0]  spy_data,
   output logic [SPY_AW-1:0]      spy_waddr
);
   localparam int              DEPTH      = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_V   = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0] AF_V      = (FIFO_AW+1)'(AF_MARGIN);
   localparam int              ROI_DEPTH  = 1 << ROI_AW;
   localparam logic [ROI_AW:0] ROI_DEPTH_V = (ROI_AW+1)'(ROI_DEPTH);
   // A margin as large as the whole RoI FIFO would read almost-full while
   // empty, so it is capped at one entry short of the depth.
   localparam int              ROI_MARGIN = (AF_MARGIN < ROI_DEPTH) ? AF_MARGIN : ROI_DEPTH - 1;
   localparam logic [ROI_AW:0] ROI_AF_V   = (ROI_AW+1)'(ROI_MARGIN);
   localparam int              SPY_DEPTH  = 1 << SPY_AW;
   localparam int              SPY_W      = HIT_W + CH_W;
   localparam logic [CH_W:0]   NCH_V      = (CH_W+1)'(N_CH);
   localparam logic [CH_W-1:0] LAST_CH    = CH_W'(N_CH - 1);

   typedef enum logic [1:0] {S_IDLE, S_ROI, S_STREAM, S_END} state_t;

   state_t            state_r, state_nxt_s;
   logic [9:0]        cnt_r;
   logic [N_CH-1:0]   empty_s, full_s, pop_s;
   logic [HIT_W-1:0]  head_s [N_CH];
   logic              flush_s;
   logic [CH_W-1:0]   rr_r, rr_nxt_s, grant_s;
   logic              grant_vld_s, load_s, drained_s, eof_set_s;
   logic [HIT_W-1:0]  out_hit_r;
   logic [CH_W-1:0]   out_ch_r;
   logic              hit_vld_r, roi_vld_r, eof_r;
   logic [ROI_W-1:0]  out_roi_r;
   logic              accept_s, spy_we_s;
   logic [SPY_AW-1:0] spy_waddr_r;
   logic [SPY_W-1:0]  spy_data_r;
   logic [SPY_W-1:0]  spy_mem_r [SPY_DEPTH];

   // ---------------- per-channel hit FIFOs ----------------
   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic [FIFO_AW:0] wr_ptr_r, rd_ptr_r, occ_s;
      logic [HIT_W-1:0] mem_r [DEPTH];
      logic             wr_ok_s, ovf_r;

      assign occ_s         = wr_ptr_r - rd_ptr_r;
      assign full_s[g]     = (occ_s == DEPTH_V);
      assign empty_s[g]    = (occ_s == '0);
      assign mdt_hit_af[g] = ((DEPTH_V - occ_s) <= AF_V);
      assign head_s[g]     = mem_r[rd_ptr_r[FIFO_AW-1:0]];
      assign wr_ok_s       = mdt_hit_we[g] && !full_s[g];
      assign hit_ovf[g]    = ovf_r;

      // Pointers and sticky overflow; a flush jumps the read pointer to the
      // pre-write write pointer so a same-cycle write survives.
      always_ff @(posedge clock) begin
         if (!resetbar) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            ovf_r    <= 1'b0;
         end else begin
            if (wr_ok_s) wr_ptr_r <= wr_ptr_r + (FIFO_AW+1)'(1);
            if (flush_s)       rd_ptr_r <= wr_ptr_r;
            else if (pop_s[g]) rd_ptr_r <= rd_ptr_r + (FIFO_AW+1)'(1);
            if (mdt_hit_we[g] && full_s[g]) ovf_r <= 1'b1;
         end
      end

      // Hit storage; validity is defined by the pointers alone
      always_ff @(posedge clock) begin
         if (wr_ok_s) mem_r[wr_ptr_r[FIFO_AW-1:0]] <= mdt_hit[g*HIT_W +: HIT_W];
      end
   end

   // ---------------- RoI FIFO ----------------
   logic [ROI_AW:0]  roi_wr_r, roi_rd_r, roi_occ_s;
   logic [ROI_W-1:0] roi_mem_r [ROI_DEPTH];
   logic             roi_empty_s, roi_wr_ok_s, roi_pop_s;

   assign roi_occ_s   = roi_wr_r - roi_rd_r;
   assign roi_empty_s = (roi_occ_s == '0);
   assign roi_wr_ok_s = roi_we && (roi_occ_s != ROI_DEPTH_V);
   assign roi_af      = ((ROI_DEPTH_V - roi_occ_s) <= ROI_AF_V);
   assign roi_pop_s   = (state_r == S_IDLE) && !roi_empty_s;

   // RoI FIFO pointers
   always_ff @(posedge clock) begin
      if (!resetbar) begin
         roi_wr_r <= '0;
         roi_rd_r <= '0;
      end else begin
         if (roi_wr_ok_s) roi_wr_r <= roi_wr_r + (ROI_AW+1)'(1);
         if (roi_pop_s)   roi_rd_r <= roi_rd_r + (ROI_AW+1)'(1);
      end
   end

   // RoI storage
   always_ff @(posedge clock) begin
      if (roi_wr_ok_s) roi_mem_r[roi_wr_r[ROI_AW-1:0]] <= roi;
   end

   // ---------------- arbitration ----------------
   // Round-robin search for the first non-empty channel starting at rr_r
   always_comb begin
      logic [CH_W:0] sum_v;
      logic          take_v;
      sum_v       = '0;
      take_v      = 1'b0;
      grant_vld_s = 1'b0;
      grant_s     = '0;
      for (int k = 0; k < N_CH; k++) begin
         sum_v       = {1'b0, rr_r} + (CH_W+1)'(k);
         sum_v       = (sum_v >= NCH_V) ? (sum_v - NCH_V) : sum_v;
         take_v      = !grant_vld_s && !empty_s[sum_v[CH_W-1:0]];
         grant_s     = take_v ? sum_v[CH_W-1:0] : grant_s;
         grant_vld_s = grant_vld_s | take_v;
      end
   end

   assign drained_s = !hit_vld_r || eng.out_hit_rdy;
   assign load_s    = (state_r == S_STREAM) && grant_vld_s && drained_s;
   assign rr_nxt_s  = (grant_s == LAST_CH) ? '0 : grant_s + CH_W'(1);
   assign flush_s   = (DROP_STALE != 0) && (state_r == S_ROI);

   // One-hot pop of the granted channel when the output register loads
   always_comb begin
      pop_s = '0;
      if (load_s) begin
         pop_s[grant_s] = 1'b1;
      end else begin
         pop_s = '0;
      end
   end

   // ---------------- FSM ----------------
   // Next-state logic; o_eof is raised on the edge where the window ends with
   // an empty output register, so it appears the cycle after the last hit.
   always_comb begin
      state_nxt_s = state_r;
      eof_set_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (!roi_empty_s) state_nxt_s = S_ROI;
            else              state_nxt_s = S_IDLE;
         end
         S_ROI: state_nxt_s = S_STREAM;
         S_STREAM: begin
            if ((cnt_r == 10'd1) || i_eof) begin
               if (!load_s && drained_s) begin
                  eof_set_s   = 1'b1;
                  state_nxt_s = S_IDLE;
               end else begin
                  state_nxt_s = S_END;
               end
            end else begin
               state_nxt_s = S_STREAM;
            end
         end
         S_END: begin
            if (drained_s) begin
               eof_set_s   = 1'b1;
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_END;
            end
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // State, window counter and engine-facing output registers
   always_ff @(posedge clock) begin
      if (!resetbar) begin
         state_r   <= S_IDLE;
         cnt_r     <= 10'd0;
         rr_r      <= '0;
         out_hit_r <= '0;
         out_ch_r  <= '0;
         hit_vld_r <= 1'b0;
         roi_vld_r <= 1'b0;
         out_roi_r <= '0;
         eof_r     <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         roi_vld_r <= roi_pop_s;
         eof_r     <= eof_set_s;
         if (roi_pop_s) begin
            out_roi_r <= roi_mem_r[roi_rd_r[ROI_AW-1:0]];
            cnt_r     <= (histogram_accumulation_count == 10'd0) ? 10'd1
                                                                 : histogram_accumulation_count;
         end else if (state_r == S_STREAM) begin
            cnt_r <= cnt_r - 10'd1;
         end
         if (load_s) begin
            out_hit_r <= head_s[grant_s];
            out_ch_r  <= grant_s;
            hit_vld_r <= 1'b1;
            rr_r      <= rr_nxt_s;
         end else if (eng.out_hit_rdy) begin
            hit_vld_r <= 1'b0;
         end
      end
   end

   assign eng.out_roi     = out_roi_r;
   assign eng.out_roi_vld = roi_vld_r;
   assign eng.out_hit     = out_hit_r;
   assign eng.out_hit_ch  = out_ch_r;
   assign eng.out_hit_vld = hit_vld_r;
   assign eng.o_eof       = eof_r;

   // ---------------- spy ring ----------------
   assign accept_s = hit_vld_r && eng.out_hit_rdy;
   assign spy_we_s = accept_s && !freeze;

   // Spy write pointer, advancing on each recorded hit
   always_ff @(posedge clock) begin
      if (!resetbar) spy_waddr_r <= '0;
      else if (spy_we_s) spy_waddr_r <= spy_waddr_r + SPY_AW'(1);
   end

   // Spy storage of {channel, hit}
   always_ff @(posedge clock) begin
      if (spy_we_s) spy_mem_r[spy_waddr_r] <= {out_ch_r, out_hit_r};
   end

   // Registered spy read port
   always_ff @(posedge clock) begin
      if (!resetbar) spy_data_r <= '0;
      else           spy_data_r <= spy_mem_r[spy_addr];
   end

   assign spy_data  = spy_data_r;
   assign spy_waddr = spy_waddr_r;
endmodule

// File: tb/tb_lsf_hit_sequencer.sv
// Directed bench for lsf_hit_sequencer: one instance keeps stale hits,
// a second one flushes them on each RoI.
module tb_lsf_hit_sequencer;
   localparam int N_CH = 3, HIT_W = 16, ROI_W = 24, FIFO_AW = 5, ROI_AW = 2;
   localparam int AF_MARGIN = 4, SPY_AW = 6, CH_W = 2, SP_W = HIT_W + CH_W;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic                  resetbar;
   logic [N_CH*HIT_W-1:0] mdt_hit;
   logic [N_CH-1:0]       mdt_hit_we;
   logic [ROI_W-1:0]      roi;
   logic                  roi_we, i_eof, freeze, rdy, sel;
   logic [9:0]            hac;
   logic [SPY_AW-1:0]     spy_addr;
   logic [N_CH-1:0]       af_a, ovf_a, af_b, ovf_b;
   logic                  roi_af_a, roi_af_b;
   logic [SP_W-1:0]       spy_data_a, spy_data_b;
   logic [SPY_AW-1:0]     spy_waddr_a, spy_waddr_b;

   lsf_hit_sequencer_if #(.N_CH(N_CH), .HIT_W(HIT_W), .ROI_W(ROI_W)) eng_a ();
   lsf_hit_sequencer_if #(.N_CH(N_CH), .HIT_W(HIT_W), .ROI_W(ROI_W)) eng_b ();
   assign eng_a.out_hit_rdy = rdy;
   assign eng_b.out_hit_rdy = rdy;

   lsf_hit_sequencer #(.N_CH(N_CH), .HIT_W(HIT_W), .ROI_W(ROI_W), .FIFO_AW(FIFO_AW),
      .ROI_AW(ROI_AW), .AF_MARGIN(AF_MARGIN), .DROP_STALE(0), .SPY_AW(SPY_AW)) u_dut (
      .clock(clock), .resetbar(resetbar), .mdt_hit(mdt_hit), .mdt_hit_we(mdt_hit_we),
      .mdt_hit_af(af_a), .hit_ovf(ovf_a), .roi(roi), .roi_we(roi_we), .roi_af(roi_af_a),
      .histogram_accumulation_count(hac), .i_eof(i_eof), .eng(eng_a), .freeze(freeze),
      .spy_addr(spy_addr), .spy_data(spy_data_a), .spy_waddr(spy_waddr_a));

   lsf_hit_sequencer #(.N_CH(N_CH), .HIT_W(HIT_W), .ROI_W(ROI_W), .FIFO_AW(FIFO_AW),
      .ROI_AW(ROI_AW), .AF_MARGIN(AF_MARGIN), .DROP_STALE(1), .SPY_AW(SPY_AW)) u_dut_ds (
      .clock(clock), .resetbar(resetbar), .mdt_hit(mdt_hit), .mdt_hit_we(mdt_hit_we),
      .mdt_hit_af(af_b), .hit_ovf(ovf_b), .roi(roi), .roi_we(roi_we), .roi_af(roi_af_b),
      .histogram_accumulation_count(hac), .i_eof(i_eof), .eng(eng_b), .freeze(freeze),
      .spy_addr(spy_addr), .spy_data(spy_data_b), .spy_waddr(spy_waddr_b));

   // monitored instance: sel=0 keeps stale hits, sel=1 flushes them
   logic             m_roi_vld, m_hit_vld, m_eof;
   logic [ROI_W-1:0] m_roi;
   logic [HIT_W-1:0] m_hit;
   logic [CH_W-1:0]  m_ch;
   assign m_roi_vld = sel ? eng_b.out_roi_vld : eng_a.out_roi_vld;
   assign m_roi     = sel ? eng_b.out_roi     : eng_a.out_roi;
   assign m_hit_vld = sel ? eng_b.out_hit_vld : eng_a.out_hit_vld;
   assign m_hit     = sel ? eng_b.out_hit     : eng_a.out_hit;
   assign m_ch      = sel ? eng_b.out_hit_ch  : eng_a.out_hit_ch;
   assign m_eof     = sel ? eng_b.o_eof       : eng_a.o_eof;

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [HIT_W-1:0] mk_hit(input int ch, input int seq);
      return {4'(ch), 4'h5, 8'(seq)};
   endfunction

   logic [HIT_W-1:0] got_hit [$];
   logic [CH_W-1:0]  got_ch  [$];
   logic [ROI_W-1:0] got_roi;
   int roi_cyc, eof_cyc, n_eof, n_roi;

   task automatic do_reset();
      resetbar = 1'b0; mdt_hit = '0; mdt_hit_we = '0; roi = '0; roi_we = 1'b0;
      i_eof = 1'b0; freeze = 1'b0; rdy = 1'b1; hac = 10'd0; spy_addr = '0;
      repeat (3) @(negedge clock);
      resetbar = 1'b1;
      @(negedge clock);
   endtask

   task automatic push_hit(input int ch, input logic [HIT_W-1:0] d);
      mdt_hit[ch*HIT_W +: HIT_W] = d;
      mdt_hit_we = '0;
      mdt_hit_we[ch] = 1'b1;
      @(negedge clock);
      mdt_hit_we = '0;
   endtask

   // Push one RoI, then watch the monitored instance cycle by cycle (cycle 0
   // is the RoI write cycle). Optionally stall rdy after the first hit and
   // raise i_eof a fixed number of cycles after out_roi_vld.
   task automatic run_window(input logic [ROI_W-1:0] rv, input logic [9:0] cnt,
                             input int budget, input int stall_len, input int eof_rel);
      int c, stall_cnt;
      bit stalled;
      logic [HIT_W-1:0] held_hit;
      logic [CH_W-1:0]  held_ch;
      got_hit.delete(); got_ch.delete();
      roi_cyc = -1; eof_cyc = -1; n_eof = 0; n_roi = 0;
      stalled = 1'b0; stall_cnt = 0; held_hit = '0; held_ch = '0;
      roi = rv; roi_we = 1'b1; hac = cnt;
      @(negedge clock);
      roi_we = 1'b0;
      c = 1;
      while (c < budget && !(n_eof > 0 && c > eof_cyc + 2)) begin
         if (m_roi_vld) begin n_roi++; roi_cyc = c; got_roi = m_roi; end
         if (m_eof) begin n_eof++; eof_cyc = c; end
         i_eof = (eof_rel >= 0 && roi_cyc >= 0 && c == roi_cyc + eof_rel);
         if (stall_len > 0 && m_hit_vld && !stalled) begin
            stalled = 1'b1; stall_cnt = 0; held_hit = m_hit; held_ch = m_ch;
         end
         if (stalled && stall_cnt > 0 && stall_cnt <= stall_len)
            chk_val("stall_hold", {m_hit_vld, m_ch, m_hit}, {1'b1, held_ch, held_hit});
         rdy = !(stalled && stall_cnt < stall_len);
         if (stalled) stall_cnt++;
         if (m_hit_vld && rdy) begin got_hit.push_back(m_hit); got_ch.push_back(m_ch); end
         @(negedge clock);
         c++;
      end
      i_eof = 1'b0; rdy = 1'b1;
      chk_val("eof_seen", 64'(n_eof), 64'd1);
      chk_val("roi_seen", 64'(n_roi), 64'd1);
   endtask

   // Check the six hits of the 2-per-channel round-robin scenario
   task automatic chk_rr6(input string tag);
      chk_val({tag, "_count"}, 64'(got_hit.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < got_hit.size())
            chk_val({tag, "_hit"}, {got_ch[i], got_hit[i]}, {2'(i % 3), mk_hit(i % 3, i / 3)});
      end
   endtask

   initial begin
      sel = 1'b0;
      do_reset();

      // reset state
      chk_val("rst_strobes", {eng_a.out_roi_vld, eng_a.out_hit_vld, eng_a.o_eof}, 64'd0);
      chk_val("rst_flags", {af_a, ovf_a, roi_af_a}, 64'd0);
      chk_val("rst_spy", {spy_waddr_a, spy_data_a}, 64'd0);
      chk_val("rst_data", {eng_a.out_hit, eng_a.out_hit_ch, eng_a.out_roi}, 64'd0);

      // empty window, count=4
      run_window(24'hABC001, 10'd4, 40, 0, -1);
      chk_val("t1_roi_cyc", 64'(roi_cyc), 64'd2);
      chk_val("t1_roi_data", 64'(got_roi), 64'hABC001);
      chk_val("t1_eof_gap", 64'(eof_cyc - roi_cyc), 64'd5);
      chk_val("t1_no_hits", 64'(got_hit.size()), 64'd0);

      // round robin, two hits per channel
      do_reset();
      for (int s = 0; s < 2; s++)
         for (int ch = 0; ch < N_CH; ch++) push_hit(ch, mk_hit(ch, s));
      run_window(24'h000222, 10'd20, 60, 0, -1);
      chk_rr6("t2");
      chk_val("t2_eof_gap", 64'(eof_cyc - roi_cyc), 64'd21);

      // same with 5-cycle backpressure after the first hit
      do_reset();
      for (int s = 0; s < 2; s++)
         for (int ch = 0; ch < N_CH; ch++) push_hit(ch, mk_hit(ch, s));
      run_window(24'h000333, 10'd20, 60, 5, -1);
      chk_rr6("t3");
      chk_val("t3_eof_gap", 64'(eof_cyc - roi_cyc), 64'd21);

      // fill ch1 past full
      do_reset();
      for (int k = 0; k < 33; k++) begin
         push_hit(1, mk_hit(1, k));
         if (k == 26) chk_val("t4_af_27", 64'(af_a[1]), 64'd0);
         if (k == 27) chk_val("t4_af_28", 64'(af_a[1]), 64'd1);
         if (k == 31) chk_val("t4_ovf_32", 64'(ovf_a[1]), 64'd0);
         if (k == 32) chk_val("t4_ovf_33", 64'(ovf_a[1]), 64'd1);
      end
      chk_val("t4_af_other", {af_a[2], af_a[0], ovf_a[2], ovf_a[0]}, 64'd0);
      run_window(24'h000444, 10'd100, 150, 0, -1);
      chk_val("t4_count", 64'(got_hit.size()), 64'd32);
      for (int i = 0; i < got_hit.size(); i++)
         chk_val("t4_hit", {got_ch[i], got_hit[i]}, {2'd1, mk_hit(1, i)});
      chk_val("t4_after", {af_a[1], ovf_a[1]}, 64'b01);

      // stale-hit flush with early end
      do_reset();
      sel = 1'b1;
      for (int ch = 0; ch < N_CH; ch++) push_hit(ch, mk_hit(ch, 7));
      run_window(24'h000555, 10'd50, 80, 0, 2);
      chk_val("t5_no_hits", 64'(got_hit.size()), 64'd0);
      chk_val("t5_eof_gap", 64'(eof_cyc - roi_cyc), 64'd3);
      sel = 1'b0;

      // spy ring: 70 hits, then freeze and read back
      do_reset();
      for (int s = 0; s < 24; s++) begin
         mdt_hit = {mk_hit(2, s), mk_hit(1, s), mk_hit(0, s)};
         mdt_hit_we = (s < 23) ? 3'b111 : 3'b001;
         @(negedge clock);
      end
      mdt_hit_we = '0;
      run_window(24'h000666, 10'd200, 260, 0, -1);
      chk_val("t6_count", 64'(got_hit.size()), 64'd70);
      chk_val("t6_waddr", 64'(spy_waddr_a), 64'd6);
      freeze = 1'b1;
      spy_addr = 6'd5;
      @(negedge clock);
      chk_val("t6_spy5", 64'(spy_data_a), {2'd0, mk_hit(0, 23)});
      spy_addr = 6'd4;
      @(negedge clock);
      chk_val("t6_spy4", 64'(spy_data_a), {2'd2, mk_hit(2, 22)});
      spy_addr = 6'd0;
      @(negedge clock);
      chk_val("t6_spy0", 64'(spy_data_a), {2'd1, mk_hit(1, 21)});
      spy_addr = 6'd5;
      push_hit(2, mk_hit(2, 99));
      run_window(24'h000777, 10'd4, 30, 0, -1);
      chk_val("t6_frz_hit", 64'(got_hit.size()), 64'd1);
      chk_val("t6_frz_waddr", 64'(spy_waddr_a), 64'd6);
      chk_val("t6_frz_spy5", 64'(spy_data_a), {2'd0, mk_hit(0, 23)});

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule

// File: doc/lsf_hit_sequencer.md
Name: lsf_hit_sequencer

Overview:
Parametrised front end for the Legendre segment finder. It buffers N_CH independent MDT hit streams plus one RoI stream in per-channel FIFOs and sequences them into a single engine-facing stream: one RoI, then round-robin hits for a programmable accumulation window, then an end-of-window pulse. It adds output backpressure, per-channel overflow flags, a stale-hit flush mode and a freezable spy ring of emitted hits. It sits between the HEG outputs and the Legendre engine input.

Parameters:
N_CH, 3, number of hit input channels (1..8)
HIT_W, HEG2SFHIT_LEN, hit word width
ROI_W, HEG2SFSLC_LEN, RoI word width
FIFO_AW, 5, log2 depth of each hit FIFO
ROI_AW, 2, log2 depth of RoI FIFO
AF_MARGIN, 4, almost-full asserts when free entries <= AF_MARGIN
DROP_STALE, 0, 1 = flush all hit FIFOs when a new RoI is popped
SPY_AW, 6, log2 depth of spy ring

Ports:
clock  in  1  single clock, all logic rising-edge
resetbar  in  1  synchronous active-low reset
mdt_hit  in  N_CH*HIT_W  packed hits, channel i at [i*HIT_W +: HIT_W]
mdt_hit_we  in  N_CH  per-channel write strobe
mdt_hit_af  out  N_CH  per-channel almost-full
hit_ovf  out  N_CH  sticky overflow flag (write while full)
roi  in  ROI_W  RoI word
roi_we  in  1  RoI write strobe
roi_af  out  1  RoI FIFO almost-full
histogram_accumulation_count  in  10  window length in cycles, sampled at RoI pop
i_eof  in  1  forces early window end
out_roi  out  ROI_W  RoI to engine
out_roi_vld  out  1  one-cycle RoI strobe
out_hit  out  HIT_W  hit to engine
out_hit_ch  out  $clog2(N_CH) (min 1)  source channel of out_hit
out_hit_vld  out  1  hit valid
out_hit_rdy  in  1  engine accepts hit
o_eof  out  1  one-cycle end-of-window pulse
freeze  in  1  1 = stop spy ring writes
spy_addr  in  SPY_AW  spy read address
spy_data  out  HIT_W+$clog2(N_CH)  {ch, hit} at spy_addr, 1-cycle read latency
spy_waddr  out  SPY_AW  next spy write pointer

Behaviour:
- Reset (resetbar=0 at edge): all FIFOs empty, FSM=IDLE, all outputs 0 (af, ovf, vld, eof, spy_waddr, out data), round-robin pointer=0.
- Writes: accepted when FIFO not full; write to full FIFO is dropped and sets hit_ovf[i] (cleared only by reset). Simultaneous read and write on a full FIFO: read completes, write dropped. Almost-full is combinational on occupancy.
- FSM states IDLE, ROI, STREAM, END.
- IDLE: RoI FIFO non-empty -> pop RoI -> ROI.
- ROI (1 cycle): out_roi=popped word, out_roi_vld=1; window counter loaded with max(histogram_accumulation_count,1); if DROP_STALE=1, all hit FIFOs flushed this cycle (writes in the same cycle are kept) -> STREAM.
- STREAM: counter decrements each cycle. Output register holds one hit; it loads when empty or when out_hit_vld&out_hit_rdy. Grant = first non-empty channel searching from (last grant+1) mod N_CH; that channel is popped; data appears at out_hit one cycle after pop. While out_hit_vld=1 and out_hit_rdy=0, out_hit/out_hit_ch are held stable and no pop occurs. Exit -> END when counter reaches 0 or i_eof=1.
- END: no new pops; wait until output register drains (vld=0 or accepted), then o_eof=1 for exactly one cycle -> IDLE. Hits left in FIFOs are retained for the next window (unless DROP_STALE).
- i_eof outside STREAM is ignored.
- Spy: each accepted hit (vld&rdy) with freeze=0 writes {ch,hit} at spy_waddr, pointer increments, wraps modulo 2^SPY_AW. freeze=1 blocks writes and holds spy_waddr; reads always allowed.
- Reset mid-window: FSM returns to IDLE, no o_eof emitted, FIFO contents lost.

Test Plan:
- Reset, one RoI, count=4, no hits -> out_roi_vld one cycle after RoI pop, o_eof exactly 5 cycles after out_roi_vld, no out_hit_vld.
- N_CH=3, count=20, 2 hits loaded into each channel before RoI, rdy=1 -> hit order ch0,ch1,ch2,ch0,ch1,ch2, then o_eof.
- Same, rdy held 0 for 5 cycles after first hit -> out_hit stable all 5 cycles, no hit lost or duplicated, 6 hits total.
- Write 33 hits to ch1 with FIFO_AW=5, no reads -> mdt_hit_af[1]=1 from occupancy 28, hit_ovf[1]=1, later 32 hits read out.
- DROP_STALE=1, 3 stale hits then RoI -> zero hits emitted; i_eof at cycle 2 of STREAM -> o_eof on next drained cycle.
- Emit 70 hits with freeze=0, then freeze=1, read spy_addr 5 -> spy_waddr=6, spy_data = 70th emitted hit (index 69) one cycle after address.
